// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// Module : dmem_arb_pkg
// Brief  : Shared FSM encoding, requester ids and default widths for dmem_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    localparam int DEF_AW     = 8;
    localparam int DEF_DW     = 8;
    localparam int DEF_STAT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_LOAD = 1'b1;

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
// ============================================================================
// Module : dmem_arbiter_if
// Brief  : Requester, memory and status signals of the data-memory arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int AW     = DEF_AW,
    parameter int DW     = DEF_DW,
    parameter int STAT_W = DEF_STAT_W
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [AW-1:0]     addr0;
    logic [AW-1:0]     addr1;
    logic [DW-1:0]     wdata0;
    logic [DW-1:0]     wdata1;
    logic              ack0;
    logic              ack1;
    logic [DW-1:0]     rdata;
    logic [AW-1:0]     mem_a;
    logic [DW-1:0]     mem_wd;
    logic              mem_we;
    logic [DW-1:0]     mem_rd;
    logic              busy;
    logic [STAT_W-1:0] gcnt0;
    logic [STAT_W-1:0] gcnt1;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rd,
        output ack0, ack1, rdata, mem_a, mem_wd, mem_we, busy, gcnt0, gcnt1
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rd,
        input  ack0, ack1, rdata, mem_a, mem_wd, mem_we, busy, gcnt0, gcnt1
    );

endinterface

`default_nettype wire

// File: rtl/dmem_rr_pick.sv
// ============================================================================
// Module : dmem_rr_pick
// Brief  : Combinational two-way round-robin picker; prio names the favoured side.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_rr_pick
    import dmem_arb_pkg::*;
(
    input  wire  req0_i,
    input  wire  req1_i,
    input  wire  prio_i,
    output logic valid_o,
    output logic winner_o
);

    always_comb begin
        valid_o = req0_i | req1_i;
        if (req0_i && req1_i) begin
            winner_o = prio_i;
        end else begin
            winner_o = req1_i ? REQ_LOAD : REQ_CORE;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module : dmem_arbiter
// Brief  : Round-robin two-requester sequencer for a 2^AW x DW data memory.
//          Optional grant counters enabled by macro DMEM_ARB_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW     = DEF_AW,
    parameter int DW     = DEF_DW,
    parameter int STAT_W = DEF_STAT_W
) (
    input wire            clk,
    input wire            rst,
    dmem_arbiter_if.slave bus
);

    state_t        state_q;
    logic          prio_q;
    logic          winner_q;
    logic          ack0_q;
    logic          ack1_q;
    logic          busy_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_a_q;
    logic [DW-1:0] mem_wd_q;
    logic [DW-1:0] rdata_q;

    logic          pick_valid;
    logic          pick_winner;
    logic          mem_we_d;
    logic [AW-1:0] mem_a_d;
    logic [DW-1:0] mem_wd_d;

    dmem_rr_pick u_pick (
        .req0_i   (bus.req0),
        .req1_i   (bus.req1),
        .prio_i   (prio_q),
        .valid_o  (pick_valid),
        .winner_o (pick_winner)
    );

    always_comb begin
        mem_we_d = bus.we0;
        mem_a_d  = bus.addr0;
        mem_wd_d = bus.wdata0;
        if (pick_winner == REQ_LOAD) begin
            mem_we_d = bus.we1;
            mem_a_d  = bus.addr1;
            mem_wd_d = bus.wdata1;
        end
    end

    // Async reset clears mem_we at once, so an in-flight write never commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            prio_q   <= REQ_CORE;
            winner_q <= REQ_CORE;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            busy_q   <= 1'b0;
            mem_we_q <= 1'b0;
            mem_a_q  <= '0;
            mem_wd_q <= '0;
            rdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    mem_we_q <= 1'b0;
                    if (pick_valid) begin
                        mem_we_q <= mem_we_d;
                        mem_a_q  <= mem_a_d;
                        mem_wd_q <= mem_wd_d;
                        winner_q <= pick_winner;
                        prio_q   <= ~pick_winner;
                        busy_q   <= 1'b1;
                        state_q  <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!mem_we_q) begin
                        rdata_q <= bus.mem_rd;
                    end
                    mem_we_q <= 1'b0;
                    ack0_q   <= (winner_q == REQ_CORE);
                    ack1_q   <= (winner_q == REQ_LOAD);
                    state_q  <= RESP;
                end
                RESP: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack0   = ack0_q;
    assign bus.ack1   = ack1_q;
    assign bus.rdata  = rdata_q;
    assign bus.mem_a  = mem_a_q;
    assign bus.mem_wd = mem_wd_q;
    assign bus.mem_we = mem_we_q;
    assign bus.busy   = busy_q;

`ifdef DMEM_ARB_STATS_EN
    logic [STAT_W-1:0] gcnt0_q;
    logic [STAT_W-1:0] gcnt1_q;
    logic              grant_w;

    assign grant_w = (state_q == IDLE) && pick_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
        end else if (grant_w) begin
            if (pick_winner == REQ_CORE && gcnt0_q != '1) begin
                gcnt0_q <= gcnt0_q + STAT_W'(1);
            end
            if (pick_winner == REQ_LOAD && gcnt1_q != '1) begin
                gcnt1_q <= gcnt1_q + STAT_W'(1);
            end
        end
    end

    assign bus.gcnt0 = gcnt0_q;
    assign bus.gcnt1 = gcnt1_q;
`else
    assign bus.gcnt0 = '0;
    assign bus.gcnt1 = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module : tb_dmem_arbiter
// Brief  : Directed self-checking bench for dmem_arbiter with a 256x8 memory model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] mem [0:255];

    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(8), .DW(8), .STAT_W(16)) bus ();

    dmem_arbiter #(.AW(8), .DW(8), .STAT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.mem_rd = mem[bus.mem_a];

    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_a] <= bus.mem_wd;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = 8'h00; bus.wdata0 = 8'h00;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 8'h00; bus.wdata1 = 8'h00;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Runs one complete transaction on requester id; lat counts edges from grant to ack.
    task automatic acc(input logic id, input logic we, input logic [7:0] a,
                       input logic [7:0] d, output logic [7:0] rd, output int lat);
        lat = 0;
        if (id == REQ_CORE) begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end
        forever begin
            tick();
            lat++;
            if ((id ? bus.ack1 : bus.ack0) === 1'b1) break;
            if (lat >= 10) break;
        end
        rd = bus.rdata;
        if (id == REQ_CORE) bus.req0 = 1'b0;
        else                bus.req1 = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #2;
        checks++;
        if ({bus.ack0, bus.ack1, bus.mem_we, bus.busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got ack0/ack1/we/busy=%b want 0000",
                     {bus.ack0, bus.ack1, bus.mem_we, bus.busy});
        end
        checks++;
        if ({bus.mem_a, bus.mem_wd, bus.rdata} !== 24'h0) begin
            errors++;
            $display("FAIL reset_data: got a/wd/rdata=%h want 000000",
                     {bus.mem_a, bus.mem_wd, bus.rdata});
        end
        checks++;
        if ({bus.gcnt0, bus.gcnt1} !== 32'h0) begin
            errors++;
            $display("FAIL reset_gcnt: got %h want 00000000", {bus.gcnt0, bus.gcnt1});
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h10; bus.wdata0 = 8'hA5;
        tick();
        checks++;
        if ({bus.mem_we, bus.mem_a, bus.mem_wd, bus.busy, bus.ack0} !== {1'b1, 8'h10, 8'hA5, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL wr_access: got we/a/wd/busy/ack0=%b/%h/%h/%b/%b want 1/10/a5/1/0",
                     bus.mem_we, bus.mem_a, bus.mem_wd, bus.busy, bus.ack0);
        end
        tick();
        checks++;
        if ({bus.ack0, bus.ack1, bus.mem_we} !== 3'b100) begin
            errors++;
            $display("FAIL wr_resp: got ack0/ack1/we=%b want 100", {bus.ack0, bus.ack1, bus.mem_we});
        end
        bus.req0 = 1'b0;
        tick();
        checks++;
        if ({bus.ack0, bus.busy} !== 2'b00) begin
            errors++;
            $display("FAIL wr_idle: got ack0/busy=%b want 00", {bus.ack0, bus.busy});
        end
        checks++;
        if (mem[8'h10] !== 8'hA5) begin
            errors++;
            $display("FAIL wr_commit: got mem[10]=%h want a5", mem[8'h10]);
        end
        bus.req0 = 1'b1; bus.we0 = 1'b0;
        tick();
        checks++;
        if ({bus.mem_we, bus.ack0} !== 2'b00) begin
            errors++;
            $display("FAIL rd_access: got we/ack0=%b want 00", {bus.mem_we, bus.ack0});
        end
        tick();
        checks++;
        if ({bus.ack0, bus.rdata} !== {1'b1, 8'hA5}) begin
            errors++;
            $display("FAIL rd_data: got ack0=%b rdata=%h want 1/a5", bus.ack0, bus.rdata);
        end
        bus.req0 = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous();
        logic [7:0] rd;
        int         lat;
        int         t0;
        int         t1;
        logic [7:0] r0;
        logic [7:0] r1;
        bit         both;
        acc(REQ_LOAD, 1'b1, 8'h01, 8'h11, rd, lat);
        acc(REQ_LOAD, 1'b1, 8'h02, 8'h22, rd, lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL preload_latency: got %0d want 2", lat);
        end
        pulse_reset();
        t0 = 0; t1 = 0; r0 = 8'h00; r1 = 8'h00; both = 1'b0;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h01;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h02;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (bus.ack0 === 1'b1 && bus.ack1 === 1'b1) both = 1'b1;
            if (bus.ack0 === 1'b1 && t0 == 0) begin t0 = c; r0 = bus.rdata; bus.req0 = 1'b0; end
            if (bus.ack1 === 1'b1 && t1 == 0) begin t1 = c; r1 = bus.rdata; bus.req1 = 1'b0; end
            if (t0 != 0 && t1 != 0) break;
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick();
        checks++;
        if (t0 !== 2 || r0 !== 8'h11) begin
            errors++;
            $display("FAIL sim_first: got ack0 cycle %0d rdata %h want 2/11", t0, r0);
        end
        checks++;
        if (t1 - t0 !== 3 || r1 !== 8'h22) begin
            errors++;
            $display("FAIL sim_second: got gap %0d rdata %h want 3/22", t1 - t0, r1);
        end
        checks++;
        if (both !== 1'b0) begin
            errors++;
            $display("FAIL sim_overlap: got both-ack %b want 0", both);
        end
    endtask

    task automatic test_contention();
        int   order [6];
        int   n;
        int   overlap;
        bit   rz0;
        bit   rz1;
        pulse_reset();
        n = 0; overlap = 0; rz0 = 1'b0; rz1 = 1'b0;
        for (int i = 0; i < 6; i++) order[i] = -1;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h01;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h02;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (rz0) begin bus.req0 = 1'b1; rz0 = 1'b0; end
            if (rz1) begin bus.req1 = 1'b1; rz1 = 1'b0; end
            if (bus.ack0 === 1'b1 && bus.ack1 === 1'b1) overlap++;
            if (bus.ack0 === 1'b1) begin
                if (n < 6) order[n] = 0;
                n++; bus.req0 = 1'b0; rz0 = 1'b1;
            end
            if (bus.ack1 === 1'b1) begin
                if (n < 6) order[n] = 1;
                n++; bus.req1 = 1'b0; rz1 = 1'b1;
            end
            if (n >= 6) break;
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick();
        tick();
        checks++;
        if (n !== 6) begin
            errors++;
            $display("FAIL cont_count: got %0d grants want 6", n);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (order[i] !== (i % 2)) begin
                errors++;
                $display("FAIL cont_order[%0d]: got %0d want %0d", i, order[i], i % 2);
            end
        end
        checks++;
        if (overlap !== 0) begin
            errors++;
            $display("FAIL cont_overlap: got %0d both-ack cycles want 0", overlap);
        end
    endtask

    task automatic test_boundary();
        logic [7:0] rd;
        int         lat;
        acc(REQ_CORE, 1'b1, 8'h00, 8'h5A, rd, lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL bnd_wr_latency: got %0d want 2", lat);
        end
        acc(REQ_LOAD, 1'b1, 8'hFF, 8'hC3, rd, lat);
        acc(REQ_CORE, 1'b0, 8'h00, 8'h00, rd, lat);
        checks++;
        if (rd !== 8'h5A) begin
            errors++;
            $display("FAIL bnd_rd00: got %h want 5a", rd);
        end
        acc(REQ_LOAD, 1'b0, 8'hFF, 8'h00, rd, lat);
        checks++;
        if (rd !== 8'hC3) begin
            errors++;
            $display("FAIL bnd_rdFF: got %h want c3", rd);
        end
        acc(REQ_CORE, 1'b0, 8'h00, 8'h00, rd, lat);
        checks++;
        if (rd !== 8'h5A) begin
            errors++;
            $display("FAIL bnd_alias00: got %h want 5a", rd);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [7:0] rd;
        int         lat;
        acc(REQ_CORE, 1'b0, 8'h00, 8'h00, rd, lat);
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'hFF; bus.wdata0 = 8'h3C;
        tick();
        checks++;
        if (bus.mem_we !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_we: got %b want 1", bus.mem_we);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.mem_we, bus.busy, bus.ack0, bus.ack1} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_async: got we/busy/ack0/ack1=%b want 0000",
                     {bus.mem_we, bus.busy, bus.ack0, bus.ack1});
        end
        bus.req0 = 1'b0; bus.we0 = 1'b0;
        tick();
        checks++;
        if ({bus.ack0, bus.ack1} !== 2'b00 || mem[8'hFF] !== 8'hC3) begin
            errors++;
            $display("FAIL rst_nocommit: got acks=%b mem[ff]=%h want 00/c3",
                     {bus.ack0, bus.ack1}, mem[8'hFF]);
        end
        rst = 1'b0;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'hFF;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h00;
        tick();
        checks++;
        if (bus.mem_a !== 8'hFF) begin
            errors++;
            $display("FAIL rst_prio: got mem_a=%h want ff (requester 0 favoured)", bus.mem_a);
        end
        tick();
        checks++;
        if ({bus.ack0, bus.rdata} !== {1'b1, 8'hC3}) begin
            errors++;
            $display("FAIL rst_readback: got ack0=%b rdata=%h want 1/c3", bus.ack0, bus.rdata);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_settle: got busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_stats();
        logic [7:0]  rd;
        int          lat;
        logic [15:0] exp0;
        logic [15:0] exp1;
`ifdef DMEM_ARB_STATS_EN
        exp0 = 16'd5;
        exp1 = 16'd3;
`else
        exp0 = 16'd0;
        exp1 = 16'd0;
`endif
        pulse_reset();
        for (int i = 0; i < 5; i++) acc(REQ_CORE, 1'b0, 8'(i), 8'h00, rd, lat);
        for (int i = 0; i < 3; i++) acc(REQ_LOAD, 1'b0, 8'(i), 8'h00, rd, lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL stat_latency: got %0d want 2", lat);
        end
        checks++;
        if (bus.gcnt0 !== exp0 || bus.gcnt1 !== exp1) begin
            errors++;
            $display("FAIL stat_counts: got %0d/%0d want %0d/%0d", bus.gcnt0, bus.gcnt1, exp0, exp1);
        end
        pulse_reset();
        checks++;
        if ({bus.gcnt0, bus.gcnt1} !== 32'h0) begin
            errors++;
            $display("FAIL stat_reset: got %0d/%0d want 0/0", bus.gcnt0, bus.gcnt1);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_simultaneous();
        test_contention();
        test_boundary();
        test_reset_mid_access();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the 256x8 data memory: one address/write-data/write-enable port, combinational read on address, write on rising clk.
- Requester 0 is the core load/store unit; requester 1 is the loader/debug port.
- Round-robin arbitration, one access per grant, registered memory drive, registered read data and a one-cycle ack pulse back to the winner.

Parameters:
- AW, 8, memory address width (depth 2^AW).
- DW, 8, data width.
- STAT_W, 16, width of the optional grant counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  access request; held high with fields stable until ack.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  AW  access address.
- wdata0 / wdata1  in  DW  write data.
- ack0 / ack1  out  1  one-cycle completion pulse.
- rdata  out  DW  read data, valid while the matching ack is high; shared by both requesters.
- mem_a  out  AW  to memory A.
- mem_wd  out  DW  to memory WD.
- mem_we  out  1  to memory WE.
- mem_rd  in  DW  from memory RD, combinational on mem_a.
- busy  out  1  high in ACCESS and RESP.
- gcnt0 / gcnt1  out  STAT_W  grant counters; see Optional Feature.

Behaviour:
- Reset (async, rst=1): state=IDLE; ack0=ack1=0; mem_we=0; mem_a=0; mem_wd=0; rdata=0; busy=0; prio=0 (requester 0 favoured).
  - Reset mid-ACCESS aborts immediately and mem_we drops asynchronously; a write still pending at that edge is not committed.
- State IDLE:
  - Sample req0/req1 at the edge.
  - Winner: if only one request is high, that requester wins; if both are high, requester prio wins.
  - On any winner: latch mem_a=addrN, mem_wd=wdataN, mem_we=weN, store the winner id, toggle prio to the loser (prio=~winner), go to ACCESS.
  - No request: stay in IDLE; mem_we=0.
- State ACCESS (exactly 1 cycle):
  - mem_a/mem_wd/mem_we are stable; the memory commits the write at the closing edge.
  - On a read, rdata<=mem_rd at the closing edge; on a write, rdata holds its prior value.
  - At the closing edge: mem_we<=0, ackN<=1 for the winner, go to RESP.
- State RESP (exactly 1 cycle):
  - ackN is high; at the closing edge ackN<=0 and the state returns to IDLE.
  - The requester must drop req by the edge ending RESP, or IDLE treats it as a new request.
- Latency: req sampled at edge E → ack high in cycle E+2. Single-requester throughput is one access per 3 cycles.
- Fairness: under continuous dual requests, grants alternate 0,1,0,1. A requester waits at most one foreign transaction.
- mem_a/mem_wd hold their last value in IDLE/RESP; only mem_we gates writes.
- ack0 and ack1 are never high together.
- rdata is not cleared between transactions.
- Requests arriving in ACCESS/RESP are not lost; they are evaluated on return to IDLE.
- Fields that change while req is held before the grant edge are sampled at that edge; later changes are ignored.
- Address wrap: none; addr is a direct AW-bit index, all 2^AW locations are valid.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- Defined:
  - gcnt0/gcnt1 increment on each IDLE→ACCESS grant to that requester.
  - The counters saturate at 2^STAT_W-1 and reset to 0.
- Undefined: gcnt0/gcnt1 are tied to 0 and no counter flops are synthesised. Arbitration timing is identical either way.

Decomposition:
- Package dmem_arb_pkg:
  - state encoding: IDLE=2'b00, ACCESS=2'b01, RESP=2'b10;
  - requester id constants REQ_CORE=1'b0, REQ_LOAD=1'b1;
  - default widths AW/DW.
- One natural sub-module: dmem_rr_pick, the combinational 2-way round-robin picker taking (req0, req1, prio) and producing (valid, winner).
- The FSM, latches and counters stay in dmem_arbiter.

Test Plan:
- Single write then read:
  - req0 writes addr 8'h10, data 8'hA5; ack0 arrives at E+2 and mem_we is high only in ACCESS.
  - req0 then reads 8'h10; rdata=8'hA5 with ack0.
- Simultaneous requests after reset:
  - req0 and req1 read 8'h01/8'h02 (memory holds 8'h11/8'h22).
  - Grant goes to 0 first (ack0, rdata=8'h11), then 1 (ack1, rdata=8'h22); the second ack comes 3 cycles after the first.
- Continuous contention, 6 transactions: grant order is 0,1,0,1,0,1; ack0 and ack1 are never high together.
- Reset asserted in the ACCESS cycle of a write to 8'hFF with data 8'h3C:
  - mem_we falls immediately; no ack is issued; location 8'hFF is unchanged; the FSM is in IDLE with prio=0 after reset.
- Boundary addresses: write/read 8'h00 and 8'hFF with 8'h5A/8'hC3; both read back correctly with no aliasing.
- With DMEM_ARB_STATS_EN defined: 5 grants to req0 and 3 to req1 → gcnt0=5, gcnt1=3; reset clears both to 0. Without the macro: both read 0.
